// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers hcount/vcount from a VGA sync stream, measures geometry and tracks lock.
module vga_timing_rx #(
  parameter int CNT_W = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] hsync_len,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_active,
  output logic             locked,
  output logic             timing_err
);
  typedef enum logic [1:0] {SEARCH, MEASURE, TRACK, LOCK} state_t;
  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] x);
    return (x == ONES) ? x : x + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] ext(input logic b);
    return {{(CNT_W-1){1'b0}}, b};
  endfunction

  state_t state, state_nxt;
  logic s1_hs, s1_vs, s1_hb, s1_vb, s2_hb, s2_vb;
  logic line_start, frame_start, seen, ovf, first_line, frame_bad;
  logic line_mis, vs_bad, same, frame_ok, load, m_clr, m_inc, err;
  logic [3:0] match;
  logic [CNT_W-1:0] line_cnt, act_cnt, sync_cnt, ref_t, ref_a, ref_s, v_cnt, va_cnt;
  logic [CNT_W-1:0] m_ht, m_ha, m_hs;

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_hs, s1_vs, s1_hb, s1_vb, s2_hb, s2_vb} <= '0;
    end else begin
      {s1_hs, s1_vs, s1_hb, s1_vb} <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
      {s2_hb, s2_vb} <= {s1_hb, s1_vb};
    end
  end

  assign line_start  = s2_hb & !s1_hb;
  assign frame_start = line_start & s2_vb & !s1_vb;
  // vsync outside vertical blank means the stream itself is malformed
  assign vs_bad      = s1_vs & !s1_vb;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen       <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      seen       <= seen | line_start;
      hcount_out <= line_start ? '0 : seen ? inc(hcount_out) : hcount_out;
      vcount_out <= frame_start ? '0 : line_start ? inc(vcount_out) : vcount_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_cnt <= '0;
      act_cnt  <= '0;
      sync_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      line_cnt <= line_start ? ext(1'b1) : inc(line_cnt);
      act_cnt  <= line_start ? ext(!s1_hb) : s1_hb ? act_cnt : inc(act_cnt);
      sync_cnt <= line_start ? ext(s1_hs) : s1_hs ? inc(sync_cnt) : sync_cnt;
      ovf      <= !line_start & (ovf | (line_cnt == ONES));
    end
  end

  assign line_mis = line_start & (ovf | (!first_line &
                    ((line_cnt != ref_t) | (act_cnt != ref_a) | (sync_cnt != ref_s))));

  always_ff @(posedge clk) begin
    if (rst) begin
      first_line <= 1'b1;
      frame_bad  <= 1'b0;
      {ref_t, ref_a, ref_s} <= '0;
    end else begin
      if (line_start && first_line && !frame_start)
        {ref_t, ref_a, ref_s} <= {line_cnt, act_cnt, sync_cnt};
      first_line <= frame_start | (first_line & !line_start);
      frame_bad  <= frame_start ? vs_bad : frame_bad | vs_bad | line_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_cnt  <= '0;
      va_cnt <= '0;
    end else begin
      v_cnt  <= frame_start ? ext(1'b1) : line_start ? inc(v_cnt) : v_cnt;
      va_cnt <= frame_start ? ext(!s1_vb) : (line_start & !s1_vb) ? inc(va_cnt) : va_cnt;
    end
  end

  // a single-line frame never latched a reference, so its only line stands in
  assign m_ht = first_line ? line_cnt : ref_t;
  assign m_ha = first_line ? act_cnt  : ref_a;
  assign m_hs = first_line ? sync_cnt : ref_s;
  assign same = {m_ht, m_ha, m_hs, v_cnt, va_cnt} == {h_total, h_active, hsync_len, v_total, v_active};
  assign frame_ok = !frame_bad & !line_mis & same;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    m_clr     = 1'b0;
    m_inc     = 1'b0;
    err       = 1'b0;
    case (state)
      SEARCH:  if (frame_start) state_nxt = MEASURE;
      MEASURE: if (frame_start) begin
        load      = 1'b1;
        m_clr     = 1'b1;
        state_nxt = TRACK;
      end
      TRACK:   if (frame_start) begin
        load  = 1'b1;
        m_inc = frame_ok;
        m_clr = !frame_ok;
        if (frame_ok && match + 4'd1 == LOCK_N) state_nxt = LOCK;
      end
      LOCK: begin
        load  = frame_start;
        err   = line_mis | (frame_start & !frame_ok);
        m_clr = err;
        if (err) state_nxt = TRACK;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      match      <= '0;
      timing_err <= 1'b0;
      {h_total, h_active, hsync_len, v_total, v_active} <= '0;
    end else begin
      state      <= state_nxt;
      match      <= m_clr ? 4'd0 : m_inc ? match + 4'd1 : match;
      timing_err <= err;
      if (load) {h_total, h_active, hsync_len, v_total, v_active} <= {m_ht, m_ha, m_hs, v_cnt, va_cnt};
    end
  end

  assign locked = state == LOCK;
endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed checks of vga_timing_rx against a small behavioural sync generator.
module tb_vga_timing_rx;
  localparam int HMAX = 48;
  localparam int HACT = 32;
  localparam int VACT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [10:0] hcount_out, vcount_out, h_total, h_active, hsync_len, v_total, v_active;
  logic locked, timing_err;

  int n_assert = 0, n_fail = 0, err_cnt = 0, e0 = 0, k = 0;
  int gh = 0, gv = 0, vmax = 20, stretch = -1, ph = 0, pv = 0;
  bit gen_en = 1'b0, force_hb = 1'b0, chk = 1'b0, prev_hb = 1'b0, pe = 1'b0, aligned = 1'b0;

  always #5 clk = ~clk;

  vga_timing_rx #(.CNT_W(11), .LOCK_FRAMES(2)) dut (
    .clk(clk), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .h_total(h_total), .h_active(h_active), .hsync_len(hsync_len),
    .v_total(v_total), .v_active(v_active),
    .locked(locked), .timing_err(timing_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // drive one generator sample, clock it in, then sample DUT outputs 1ns after the edge
  task automatic step();
    logic e;
    int ch, cv;
    hblnk_in = (gen_en && gh >= HACT) || force_hb;
    hsync_in = gen_en && gh >= 36 && gh < 42;
    vblnk_in = gen_en && gv >= VACT;
    vsync_in = gen_en && gv >= 16 && gv < 18;
    e = prev_hb && !hblnk_in;
    prev_hb = hblnk_in;
    ch = gh;
    cv = gv;
    if (gen_en) begin
      if (gh >= ((gv == stretch) ? HMAX : HMAX - 1)) begin
        if (gv == stretch) stretch = -1;
        gh = 0;
        gv = (gv >= vmax - 1) ? 0 : gv + 1;
      end else gh++;
    end
    @(posedge clk);
    #1;
    if (timing_err) err_cnt++;
    if (pe) aligned = 1'b1;
    if (chk && aligned) begin
      check("hcount_align", hcount_out, ph);
      check("vcount_align", vcount_out, pv);
    end
    ph = ch;
    pv = cv;
    pe = e;
  endtask

  // run until the generator's frame origin has been driven and its frame_start has taken effect
  task automatic to_frame();
    int n;
    n = 0;
    while (!(gh == 0 && gv == 0) && n < 3000) begin
      step();
      n++;
    end
    check("frame_wait_bound", n < 3000, 1);
    step();
    step();
  endtask

  task automatic zero_checks(input string p);
    check({p, "_hcount"}, hcount_out, 0);
    check({p, "_vcount"}, vcount_out, 0);
    check({p, "_h_total"}, h_total, 0);
    check({p, "_h_active"}, h_active, 0);
    check({p, "_hsync_len"}, hsync_len, 0);
    check({p, "_v_total"}, v_total, 0);
    check({p, "_v_active"}, v_active, 0);
    check({p, "_locked"}, locked, 0);
    check({p, "_timing_err"}, timing_err, 0);
  endtask

  initial begin
    repeat (3) step();
    zero_checks("reset");

    rst = 1'b0;
    gen_en = 1'b1;
    chk = 1'b1;
    repeat (1921) step();
    check("h_total_before_measure", h_total, 0);
    check("locked_before_measure", locked, 0);
    step();
    check("h_total", h_total, 48);
    check("h_active", h_active, 32);
    check("hsync_len", hsync_len, 6);
    check("v_total", v_total, 20);
    check("v_active", v_active, 15);
    check("locked_after_measure", locked, 0);
    repeat (3841 - 1922) step();
    check("locked_early", locked, 0);
    step();
    check("locked_nominal", locked, 1);
    check("no_err_nominal", err_cnt, 0);
    chk = 1'b0;

    stretch = 7;
    e0 = err_cnt;
    k = 0;
    while (!timing_err && k < 2000) begin
      step();
      k++;
    end
    check("glitch_err", timing_err, 1);
    check("glitch_unlock", locked, 0);
    step();
    check("glitch_err_one_cycle", timing_err, 0);
    to_frame();
    check("glitch_frame_locked", locked, 0);
    check("glitch_frame_h_total", h_total, 48);
    to_frame();
    check("glitch_relock_early", locked, 0);
    to_frame();
    check("glitch_relock", locked, 1);
    check("glitch_err_pulses", err_cnt - e0, 1);

    vmax = 19;
    e0 = err_cnt;
    to_frame();
    check("vchange_err", timing_err, 1);
    check("vchange_unlock", locked, 0);
    check("vchange_v_total", v_total, 19);
    check("vchange_v_active", v_active, 15);
    check("vchange_h_total", h_total, 48);
    to_frame();
    check("vchange_relock_early", locked, 0);
    to_frame();
    check("vchange_relock", locked, 1);
    check("vchange_err_pulses", err_cnt - e0, 1);

    force_hb = 1'b1;
    repeat (3000) step();
    check("hcount_saturated", hcount_out, 2047);
    force_hb = 1'b0;
    k = 0;
    while (!timing_err && k < 200) begin
      step();
      k++;
    end
    check("sat_err", timing_err, 1);
    check("sat_restart_hcount", hcount_out, 0);
    check("sat_unlock", locked, 0);
    to_frame();
    check("sat_frame_no_lock", locked, 0);
    repeat (3) to_frame();
    check("sat_relock", locked, 1);

    k = 0;
    while (gv != 10 && k < 2000) begin
      step();
      k++;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    zero_checks("midreset");
    repeat (3) to_frame();
    check("midreset_relock_early", locked, 0);
    to_frame();
    check("midreset_relock", locked, 1);

    rst = 1'b1;
    gen_en = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    gen_en = 1'b1;
    gh = 10;
    gv = 5;
    e0 = err_cnt;
    repeat (39) begin
      step();
      check("capture_hold_hcount", hcount_out, 0);
      check("capture_hold_vcount", vcount_out, 0);
    end
    step();
    check("capture_first_hcount", hcount_out, 0);
    check("capture_first_vcount", vcount_out, 1);
    step();
    check("capture_count_runs", hcount_out, 1);
    k = 0;
    while (!locked && k < 8000) begin
      step();
      k++;
    end
    check("capture_lock", locked, 1);
    check("capture_no_err", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Receive-side VGA timing recovery and checking block. It consumes the hsync, vsync, hblnk and vblnk outputs of the VGA timing generator, or any equivalent sync stream, and rebuilds aligned hcount and vcount values from them. It also measures line and frame geometry and declares lock after consecutive identical frames. It sits on the consumer side of the timing interface: downstream draw/check stages, and the bench, compare its recovered counts against the generator.

## Interface
Parameters:
- CNT_W, 11, width of all counters and measurement outputs.
- LOCK_FRAMES, 2, number of consecutive consistent frames required for lock (1..15).

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, synchronous, active-high.
- hsync_in  in  1  horizontal sync, active-high.
- vsync_in  in  1  vertical sync, active-high.
- hblnk_in  in  1  horizontal blank, active-high.
- vblnk_in  in  1  vertical blank, active-high.
- hcount_out  out  CNT_W  recovered pixel count.
- vcount_out  out  CNT_W  recovered line count.
- h_total  out  CNT_W  clocks per line, from the last completed frame.
- h_active  out  CNT_W  hblnk-low clocks per line.
- hsync_len  out  CNT_W  hsync-high clocks per line.
- v_total  out  CNT_W  lines per frame.
- v_active  out  CNT_W  lines per frame starting with vblnk low.
- locked  out  1  geometry stable.
- timing_err  out  1  one-cycle pulse on a geometry violation while locked.

## Operation
- Input stage: all four inputs are registered as s1, then s1 is registered as s2.
- Edge events are evaluated on s1/s2:
  - line_start = s2.hblnk & !s1.hblnk.
  - frame_start = line_start & s2.vblnk & !s1.vblnk.
  - hblnk_rise = !s2.hblnk & s1.hblnk.
- Recovered counters:
  - On line_start: hcount_out <= 0. Otherwise hcount_out increments, saturating at 2^CNT_W-1.
  - On frame_start: vcount_out <= 0. On any other line_start: vcount_out increments (saturating). Otherwise vcount_out holds.
  - Before the first line_start after reset, both counters hold 0.
- Per-line measurement:
  - A line counter runs from line_start to line_start.
  - The active count counts cycles with s1.hblnk low.
  - The sync count counts cycles with s1.hsync high.
  - The first line of a frame sets the reference line values. Every later line whose total, active or sync count differs from the reference sets a frame_bad flag.
- Per-frame measurement:
  - Count line_starts per frame.
  - Count line_starts that occur with s1.vblnk low (v_active).
  - On frame_start, for the frame just ended, load h_total, h_active, hsync_len, v_total and v_active.
- State machine:
  - SEARCH: wait for frame_start → MEASURE.
  - MEASURE: at the next frame_start, latch the measurements, clear the match counter, then → TRACK.
  - TRACK: at each frame_start:
    - If the frame is consistent (frame_bad=0 and all five values equal the previous frame's values), the match counter increments. When it reaches LOCK_FRAMES → LOCKED.
    - If the frame is not consistent, the match counter is cleared and the state stays TRACK.
  - LOCKED: locked=1.
    - Any per-line mismatch, or a frame_start whose frame is inconsistent, drives timing_err=1 for one cycle, clears the match counter and → TRACK.
    - A line exceeding 2^CNT_W-1 clocks also counts as a mismatch.
- Reset at any time, including mid-frame: all state cleared, state returns to SEARCH.

## Timing
- Reset values: hcount_out, vcount_out, h_total, h_active, hsync_len, v_total and v_active are all 0; locked=0; timing_err=0.
- Count latency is 2 clk cycles. Once the first line_start has been seen, hcount_out(t) = generator hcount(t-2) and vcount_out(t) = generator vcount(t-2).
- Measurement outputs change only on the cycle after frame_start.
- locked rises on the cycle after the frame_start that completes LOCK_FRAMES consistent frames.
- timing_err asserts on the cycle after the offending event. locked falls on the same cycle.
- Simultaneous events: a per-line mismatch on the last line of a frame and that frame's frame_start produce a single timing_err pulse, not two.
- Saturation: counters stick at all-ones and never wrap.

## Test plan
- Nominal 800x600 (H_MAX=1056, blank start 800, V_MAX=628, 600 active lines, LOCK_FRAMES=2):
  - h_total=1056, h_active=800, v_total=628, v_active=600 after the first measured frame.
  - locked=1 at the end of the third complete frame.
  - hcount_out and vcount_out equal the generator counts delayed by 2 cycles for every cycle after the first line_start.
- Reset mid-frame: pulse rst at generator vcount=300.
  - All outputs read 0 and locked=0 on the next cycle.
  - Relock after 3 further frame_starts.
- Line-length glitch while locked: one line stretched to 1057 clocks.
  - Exactly one timing_err pulse; locked=0.
  - locked returns after 2 consistent frames.
- Frame-length change while locked: V_MAX switched 628→627.
  - timing_err at the next frame_start; v_total=627.
  - Relock after 2 frames at 627.
- Start of capture: enable the generator mid-frame while rst is low.
  - hcount_out and vcount_out hold 0 until the first hblnk falling edge.
  - No timing_err before the first lock.
- Saturation: hold hblnk_in high for 3000 cycles.
  - hcount_out sticks at 2047.
  - On release: line_start restarts hcount_out at 0 and the state machine does not reach LOCKED on that frame.
